fmul_result_stage: RTL and testbench
====================================

FMUL_RESULT_STAGE -- requirements
Module: fmul_result_stage

Interface
REQ-001 Parameter CNT_WIDTH, default 8: width of the statistics counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_Valid  input  1  upstream multiplier result valid.
REQ-005 in_Ready  output  1  stage can accept a result this cycle.
REQ-006 in_Sign / in_Exponent / in_Mantissa  input  1 / 5 / 10  half-precision product fields from the multiplier.
REQ-007 in_SC_Exponent_Overflow / in_SC_Exponent_Underflow  input  1 / 1  multiplier exception flags.
REQ-008 out_Valid  output  1  packed result available.
REQ-009 out_Ready  input  1  downstream accepts the result.
REQ-010 out_Result  output  16  packed word {sign, exponent[5], mantissa[10]}, sign in MSB.
REQ-011 out_Exception  output  2  {overflow, underflow} tag travelling with out_Result.
REQ-012 in_Clear_Sticky  input  1  synchronous clear of sticky flags.
REQ-013 Sticky_Overflow / Sticky_Underflow  output  1 / 1  accumulated exception flags.
REQ-014 Count_Results / Count_Exceptions  output  CNT_WIDTH each  statistics counters.

Function
REQ-015 Input transfer occurs when in_Valid and in_Ready are both 1 on a rising edge; output transfer occurs when out_Valid and out_Ready are both 1.
REQ-016 Results are held in a 2-entry FIFO (write pointer, read pointer, 2-bit occupancy count); order is preserved.
REQ-017 in_Ready = (occupancy < 2) OR (occupancy == 2 AND out_Ready): simultaneous push and pop when full is accepted.
REQ-018 out_Valid = (occupancy != 0); out_Result and out_Exception come from the read entry and are registered, not combinational from inputs.
REQ-019 Latency: a result accepted in cycle N appears on out_Result in cycle N+1 when the FIFO was empty.
REQ-020 Packing at write: overflow flag set -> stored word {in_Sign, 11111, 1111111111}; else underflow flag set -> {in_Sign, 00000, 0000000000}; else {in_Sign, in_Exponent, in_Mantissa}.
REQ-021 When both flags are set, overflow wins; out_Exception stores both raw flags unchanged.
REQ-022 Simultaneous push and pop at occupancy 1 or 2 leaves occupancy unchanged; pointers each advance by one and wrap modulo 2.
REQ-023 Pop with occupancy 0 and push with occupancy 2 without a concurrent pop are impossible by the handshake and cause no state change.
REQ-024 Sticky flags set on an accepted input carrying the corresponding flag; in_Clear_Sticky clears them; a clear and a set in the same cycle leave the flag set.
REQ-025 out_Result and out_Valid are held stable while out_Valid=1 and out_Ready=0.

Reset
REQ-026 While rst_n=0: occupancy 0, both pointers 0, out_Valid 0, out_Result 0, out_Exception 0, both sticky flags 0, counters 0, in_Ready 1.
REQ-027 Reset mid-operation discards all stored results immediately, without waiting for a clock edge.
REQ-028 The first transfer after deassertion is accepted on the first rising edge with rst_n=1.

Configuration
REQ-029 Macro FMUL_RESULT_STATS_EN defined: Count_Results increments on each output transfer; Count_Exceptions increments on each output transfer with a nonzero out_Exception; both saturate at all-ones.
REQ-030 Macro FMUL_RESULT_STATS_EN undefined: no counter registers are instantiated; Count_Results and Count_Exceptions are constant 0; all other behaviour is identical.

Verification
REQ-031 Push sign=1, exp=10010, man=0000000101 with out_Ready=1 -> next cycle out_Valid=1, out_Result=16'hC805, out_Exception=00.
REQ-032 Push with overflow=1, sign=0 -> out_Result=16'h7FFF, out_Exception=10, Sticky_Overflow=1 until in_Clear_Sticky is pulsed.
REQ-033 Push with both flags set, sign=1 -> out_Result=16'hFFFF, out_Exception=11, both sticky flags 1.
REQ-034 out_Ready=0, push 3 results -> third push stalls with in_Ready=0; raise out_Ready -> results emerge in order, and a push concurrent with the pop while full is accepted.
REQ-035 Two entries held, assert rst_n=0 between edges -> out_Valid drops to 0 immediately; after release, occupancy is 0 and in_Ready=1.
REQ-036 With FMUL_RESULT_STATS_EN and CNT_WIDTH=8, 300 output transfers, 1 of them flagged -> Count_Results=255 and Count_Exceptions=1; without the macro both counters read 0.

Source files
------------

// File: rtl/fmul_result_stage_if.sv
// Handshake and data bundle between the FP16 multiplier, the result stage
// and the downstream consumer. The master side drives results in and takes
// results out; the slave side is the result stage itself.
interface fmul_result_stage_if;
    logic        in_Valid;
    logic        in_Ready;
    logic        in_Sign;
    logic [4:0]  in_Exponent;
    logic [9:0]  in_Mantissa;
    logic        in_SC_Exponent_Overflow;
    logic        in_SC_Exponent_Underflow;
    logic        out_Valid;
    logic        out_Ready;
    logic [15:0] out_Result;
    logic [1:0]  out_Exception;

    modport master (
        output in_Valid, in_Sign, in_Exponent, in_Mantissa,
               in_SC_Exponent_Overflow, in_SC_Exponent_Underflow, out_Ready,
        input  in_Ready, out_Valid, out_Result, out_Exception
    );

    modport slave (
        input  in_Valid, in_Sign, in_Exponent, in_Mantissa,
               in_SC_Exponent_Overflow, in_SC_Exponent_Underflow, out_Ready,
        output in_Ready, out_Valid, out_Result, out_Exception
    );
endinterface

// File: rtl/fmul_result_stage.sv
// FP16 multiplier result stage: packs sign/exponent/mantissa into a 16-bit
// word (forcing Inf-like/zero patterns on exception), buffers it in a
// 2-entry FIFO, and keeps sticky exception flags.
// Optional statistics counters are built only when FMUL_RESULT_STATS_EN is
// defined; otherwise Count_Results/Count_Exceptions are tied to zero.
module fmul_result_stage #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fmul_result_stage_if.slave   bus,
    input  logic                 in_Clear_Sticky,
    output logic                 Sticky_Overflow,
    output logic                 Sticky_Underflow,
    output logic [CNT_WIDTH-1:0] Count_Results,
    output logic [CNT_WIDTH-1:0] Count_Exceptions
);

    // Overflow dominates underflow; the raw flags travel separately.
    function automatic logic [15:0] pack_word(input logic       sign,
                                              input logic [4:0] expo,
                                              input logic [9:0] mant,
                                              input logic       ovf,
                                              input logic       unf);
        logic [15:0] word;
        if (ovf) begin
            word = {sign, 5'b11111, 10'h3FF};
        end else if (unf) begin
            word = {sign, 15'h0000};
        end else begin
            word = {sign, expo, mant};
        end
        return word;
    endfunction

    logic [1:0][15:0] mem_r;
    logic [1:0][1:0]  exc_r;
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic             out_valid_r;
    logic [15:0]      out_result_r;
    logic [1:0]       out_exception_r;
    logic             sticky_ovf_r;
    logic             sticky_unf_r;

    logic [1:0][15:0] mem_next_s;
    logic [1:0][1:0]  exc_next_s;
    logic             wr_next_s;
    logic             rd_next_s;
    logic [1:0]       count_next_s;
    logic             in_ready_s;
    logic             push_s;
    logic             pop_s;
    logic             sticky_ovf_next_s;
    logic             sticky_unf_next_s;

    // Handshake qualifiers and next FIFO / sticky state.
    always_comb begin
        in_ready_s   = (count_r < 2'd2) || ((count_r == 2'd2) && bus.out_Ready);
        push_s       = bus.in_Valid && in_ready_s;
        pop_s        = out_valid_r && bus.out_Ready;
        mem_next_s   = mem_r;
        exc_next_s   = exc_r;
        wr_next_s    = wr_ptr_r;
        rd_next_s    = rd_ptr_r;
        count_next_s = count_r;
        if (push_s) begin
            mem_next_s[wr_ptr_r] = pack_word(bus.in_Sign, bus.in_Exponent, bus.in_Mantissa,
                                             bus.in_SC_Exponent_Overflow,
                                             bus.in_SC_Exponent_Underflow);
            exc_next_s[wr_ptr_r] = {bus.in_SC_Exponent_Overflow, bus.in_SC_Exponent_Underflow};
            wr_next_s            = ~wr_ptr_r;
        end else begin
            wr_next_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_next_s = ~rd_ptr_r;
        end else begin
            rd_next_s = rd_ptr_r;
        end
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + 2'd1;
            2'b01:   count_next_s = count_r - 2'd1;
            default: count_next_s = count_r;
        endcase
        // A set in the same cycle as a clear wins.
        sticky_ovf_next_s = (sticky_ovf_r && !in_Clear_Sticky) ||
                            (push_s && bus.in_SC_Exponent_Overflow);
        sticky_unf_next_s = (sticky_unf_r && !in_Clear_Sticky) ||
                            (push_s && bus.in_SC_Exponent_Underflow);
    end

    // FIFO storage, pointers, registered head entry and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r           <= {2{16'h0000}};
            exc_r           <= {2{2'b00}};
            wr_ptr_r        <= 1'b0;
            rd_ptr_r        <= 1'b0;
            count_r         <= 2'd0;
            out_valid_r     <= 1'b0;
            out_result_r    <= 16'h0000;
            out_exception_r <= 2'b00;
            sticky_ovf_r    <= 1'b0;
            sticky_unf_r    <= 1'b0;
        end else begin
            mem_r           <= mem_next_s;
            exc_r           <= exc_next_s;
            wr_ptr_r        <= wr_next_s;
            rd_ptr_r        <= rd_next_s;
            count_r         <= count_next_s;
            // Head entry is preloaded so it is visible the cycle after a write.
            out_valid_r     <= (count_next_s != 2'd0);
            out_result_r    <= mem_next_s[rd_next_s];
            out_exception_r <= exc_next_s[rd_next_s];
            sticky_ovf_r    <= sticky_ovf_next_s;
            sticky_unf_r    <= sticky_unf_next_s;
        end
    end

    assign bus.in_Ready      = in_ready_s;
    assign bus.out_Valid     = out_valid_r;
    assign bus.out_Result    = out_result_r;
    assign bus.out_Exception = out_exception_r;
    assign Sticky_Overflow   = sticky_ovf_r;
    assign Sticky_Underflow  = sticky_unf_r;

`ifdef FMUL_RESULT_STATS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] cnt_results_r;
    logic [CNT_WIDTH-1:0] cnt_exceptions_r;

    // Saturating counts of delivered results and of delivered flagged results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_results_r    <= {CNT_WIDTH{1'b0}};
            cnt_exceptions_r <= {CNT_WIDTH{1'b0}};
        end else begin
            if (pop_s && (cnt_results_r != CNT_MAX)) begin
                cnt_results_r <= cnt_results_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
            if (pop_s && (out_exception_r != 2'b00) && (cnt_exceptions_r != CNT_MAX)) begin
                cnt_exceptions_r <= cnt_exceptions_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign Count_Results    = cnt_results_r;
    assign Count_Exceptions = cnt_exceptions_r;
`else
    assign Count_Results    = {CNT_WIDTH{1'b0}};
    assign Count_Exceptions = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_fmul_result_stage.sv
// Scoreboard bench for fmul_result_stage: a driver issues directed and random
// results and queues the expected packed words; a monitor compares the DUT
// output against the queue head every cycle.
module tb_fmul_result_stage;
    localparam int CNT_WIDTH = 8;

    logic                 clk;
    logic                 rst_n;
    logic                 clr;
    logic                 sticky_ovf;
    logic                 sticky_unf;
    logic [CNT_WIDTH-1:0] cnt_res;
    logic [CNT_WIDTH-1:0] cnt_exc;

    fmul_result_stage_if bus_if ();

    fmul_result_stage #(.CNT_WIDTH(CNT_WIDTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .bus              (bus_if),
        .in_Clear_Sticky  (clr),
        .Sticky_Overflow  (sticky_ovf),
        .Sticky_Underflow (sticky_unf),
        .Count_Results    (cnt_res),
        .Count_Exceptions (cnt_exc)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [17:0] exp_q[$];
    bit          mon_en = 1'b0;
    bit          m_sov = 1'b0;
    bit          m_sun = 1'b0;
    int          m_cres = 0;
    int          m_cexc = 0;
    bit          pend_v = 1'b0;
    bit          pend_ov = 1'b0;
    bit          pend_un = 1'b0;
    bit          pend_clr = 1'b0;
    logic [17:0] pend_item = 18'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference packing, straight from the value rules.
    function automatic logic [15:0] ref_pack(input bit s, input logic [4:0] e,
                                             input logic [9:0] m, input bit ov, input bit un);
        int mag;
        if (ov)      mag = 32'h7FFF;
        else if (un) mag = 0;
        else         mag = int'(e) * 1024 + int'(m);
        return 16'((s ? 32'h8000 : 0) + mag);
    endfunction

    // One cycle: retire last cycle's accepted input into the model, drive new inputs.
    task automatic drive_cycle(input bit v, input bit s, input logic [4:0] e, input logic [9:0] m,
                               input bit ov, input bit un, input bit ordy, input bit c);
        @(posedge clk);
        #1;
        if (pend_v) exp_q.push_back(pend_item);
        m_sov = (m_sov && !pend_clr) || (pend_v && pend_ov);
        m_sun = (m_sun && !pend_clr) || (pend_v && pend_un);
        bus_if.in_Valid                 = v;
        bus_if.in_Sign                  = s;
        bus_if.in_Exponent              = e;
        bus_if.in_Mantissa              = m;
        bus_if.in_SC_Exponent_Overflow  = ov;
        bus_if.in_SC_Exponent_Underflow = un;
        bus_if.out_Ready                = ordy;
        clr                             = c;
        pend_v    = v && ((exp_q.size() < 2) || ordy);
        pend_item = {ov, un, ref_pack(s, e, m, ov, un)};
        pend_ov   = ov;
        pend_un   = un;
        pend_clr  = c;
    endtask

    task automatic idle(input bit ordy);
        drive_cycle(1'b0, 1'b0, 5'd0, 10'd0, 1'b0, 1'b0, ordy, 1'b0);
    endtask

    // Monitor: compare against the scoreboard head, retire on output transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("in_ready", 32'(bus_if.in_Ready), 32'((exp_q.size() < 2) || bus_if.out_Ready));
                chk("out_valid", 32'(bus_if.out_Valid), 32'(exp_q.size() != 0));
                chk("sticky_ovf", 32'(sticky_ovf), 32'(m_sov));
                chk("sticky_unf", 32'(sticky_unf), 32'(m_sun));
`ifdef FMUL_RESULT_STATS_EN
                chk("count_results", 32'(cnt_res), 32'(m_cres));
                chk("count_exceptions", 32'(cnt_exc), 32'(m_cexc));
`else
                chk("count_results", 32'(cnt_res), 32'd0);
                chk("count_exceptions", 32'(cnt_exc), 32'd0);
`endif
                if (exp_q.size() != 0) begin
                    chk("out_result", 32'(bus_if.out_Result), 32'(exp_q[0][15:0]));
                    chk("out_exception", 32'(bus_if.out_Exception), 32'(exp_q[0][17:16]));
                    if (bus_if.out_Ready) begin
                        if (m_cres < (1 << CNT_WIDTH) - 1) m_cres++;
                        if (exp_q[0][17:16] != 2'b00 && m_cexc < (1 << CNT_WIDTH) - 1) m_cexc++;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        clr   = 1'b0;
        bus_if.in_Valid                 = 1'b0;
        bus_if.in_Sign                  = 1'b0;
        bus_if.in_Exponent              = 5'd0;
        bus_if.in_Mantissa              = 10'd0;
        bus_if.in_SC_Exponent_Overflow  = 1'b0;
        bus_if.in_SC_Exponent_Underflow = 1'b0;
        bus_if.out_Ready                = 1'b0;
        #2;
        chk("rst_out_valid", 32'(bus_if.out_Valid), 32'd0);
        chk("rst_out_result", 32'(bus_if.out_Result), 32'd0);
        chk("rst_out_exception", 32'(bus_if.out_Exception), 32'd0);
        chk("rst_in_ready", 32'(bus_if.in_Ready), 32'd1);
        chk("rst_sticky", 32'({sticky_ovf, sticky_unf}), 32'd0);
        chk("rst_counters", 32'({cnt_res, cnt_exc}), 32'd0);
        #10;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Plain product, one-cycle latency.
        drive_cycle(1'b1, 1'b1, 5'b10010, 10'b0000000101, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        #1;
        chk("plain_valid", 32'(bus_if.out_Valid), 32'd1);
        chk("plain_result", 32'(bus_if.out_Result), 32'h0000C805);
        chk("plain_exception", 32'(bus_if.out_Exception), 32'd0);

        // Overflow with sticky hold and clear.
        drive_cycle(1'b1, 1'b0, 5'd3, 10'd77, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        #1;
        chk("ovf_result", 32'(bus_if.out_Result), 32'h00007FFF);
        chk("ovf_exception", 32'(bus_if.out_Exception), 32'd2);
        chk("ovf_sticky", 32'(sticky_ovf), 32'd1);
        idle(1'b1);
        idle(1'b1);
        chk("ovf_sticky_held", 32'(sticky_ovf), 32'd1);
        drive_cycle(1'b0, 1'b0, 5'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        #1;
        chk("ovf_sticky_cleared", 32'(sticky_ovf), 32'd0);

        // Both flags: overflow wins, both raw flags kept.
        drive_cycle(1'b1, 1'b1, 5'd9, 10'd9, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        #1;
        chk("both_result", 32'(bus_if.out_Result), 32'h0000FFFF);
        chk("both_exception", 32'(bus_if.out_Exception), 32'd3);
        chk("both_sticky", 32'({sticky_ovf, sticky_unf}), 32'd3);
        drive_cycle(1'b0, 1'b0, 5'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Fill, stall, then push concurrent with pop while full.
        idle(1'b0);
        drive_cycle(1'b1, 1'b0, 5'd1, 10'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 5'd2, 10'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0, 5'd3, 10'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("full_stall", 32'(bus_if.in_Ready), 32'd0);
        drive_cycle(1'b1, 1'b0, 5'd3, 10'd3, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        chk("full_push_pop", 32'(bus_if.in_Ready), 32'd1);
        repeat (4) idle(1'b1);

        // Asynchronous reset while two entries are held.
        drive_cycle(1'b1, 1'b1, 5'd4, 10'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        drive_cycle(1'b1, 1'b1, 5'd5, 10'd5, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        #1;
        chk("pre_reset_valid", 32'(bus_if.out_Valid), 32'd1);
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus_if.out_Valid), 32'd0);
        chk("async_rst_in_ready", 32'(bus_if.in_Ready), 32'd1);
        chk("async_rst_result", 32'(bus_if.out_Result), 32'd0);
        chk("async_rst_sticky", 32'({sticky_ovf, sticky_unf}), 32'd0);
        exp_q.delete();
        pend_v = 1'b0; pend_clr = 1'b0;
        m_sov = 1'b0; m_sun = 1'b0; m_cres = 0; m_cexc = 0;
        @(negedge clk);
        #2;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        drive_cycle(1'b1, 1'b0, 5'd17, 10'd300, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        #1;
        chk("first_after_reset", 32'(bus_if.out_Valid), 32'd1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive_cycle($urandom_range(0, 9) < 7, 1'($urandom), 5'($urandom), 10'($urandom),
                        $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                        $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0);
        end
        repeat (4) idle(1'b1);
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
